threshold2_mul_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one unsigned 8x14 multiplier (the DSP48 product resource of the threshold2 datapath) among N_REQ requesters.
- Typical requesters are the pixel-scaling and coefficient paths of the threshold stage.
- Each requester uses a valid/ready port; products return in issue order on one shared result bus tagged with the requester index.
- The pipeline stalls as a whole when the result consumer back-pressures.

---
 rtl/threshold2_mul_pkg.sv | 24 ++
 rtl/threshold2_mul_core.sv | 22 ++
 rtl/threshold2_mul_arb.sv | 146 ++++++++++++++
 tb/tb_threshold2_mul_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/threshold2_mul_pkg.sv
// Shared widths, id-width helper and pipeline stage record for the threshold2
// multiplier arbiter.
package threshold2_mul_pkg;

    localparam int DIN0_W_DEF = 8;
    localparam int DIN1_W_DEF = 14;
    localparam int DOUT_W_DEF = 21;

    // Stage record fields are sized for the largest supported configuration
    // (N_REQ up to 8, DOUT_W up to 32); unused upper bits stay zero.
    localparam int ID_MAX_W   = 3;
    localparam int DATA_MAX_W = 32;

    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [ID_MAX_W-1:0]   id;
        logic [DATA_MAX_W-1:0] data;
    } stage_t;

endpackage

// File: rtl/threshold2_mul_core.sv
// Combinational unsigned DIN0_W x DIN1_W multiplier, product truncated to
// DOUT_W bits; a single product term so synthesis can map it onto one DSP48.
module threshold2_mul_core
    import threshold2_mul_pkg::*;
#(
    parameter int DIN0_W = DIN0_W_DEF,
    parameter int DIN1_W = DIN1_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF
) (
    input  logic [DIN0_W-1:0] a,
    input  logic [DIN1_W-1:0] b,
    output logic [DOUT_W-1:0] p
);

    localparam int PW = DIN0_W + DIN1_W;

    logic [PW-1:0] full_s;

    assign full_s = PW'(a) * PW'(b);
    assign p      = DOUT_W'(full_s);

endmodule

// File: rtl/threshold2_mul_arb.sv
// Round-robin arbiter sharing one multiplier among N_REQ valid/ready requesters;
// results leave in issue order, tagged with the owner id, and the whole
// pipeline freezes while the result consumer back-pressures.
module threshold2_mul_arb
    import threshold2_mul_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DIN0_W = DIN0_W_DEF,
    parameter int DIN1_W = DIN1_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF,
    parameter int STAGES = 2
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*DIN0_W-1:0]  req_a,
    input  logic [N_REQ*DIN1_W-1:0]  req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [idw(N_REQ)-1:0]    res_id,
    output logic [DOUT_W-1:0]        res_data,
    output logic                     busy,
    output logic [31:0]              op_count
);

    localparam int IDW = idw(N_REQ);

    logic [IDW-1:0]    rr_ptr_r;
    logic [IDW-1:0]    rr_next_s;
    logic [IDW-1:0]    grant_s;
    logic              found_s;
    logic              advance_s;
    logic              accept_s;
    logic [DIN0_W-1:0] a_sel_s;
    logic [DIN1_W-1:0] b_sel_s;
    logic [DOUT_W-1:0] prod_s;
    stage_t            stage_r      [STAGES];
    stage_t            stage_next_s [STAGES];
    logic              busy_r;
    logic              busy_next_s;
    logic [31:0]       op_count_r;

    assign advance_s = ~(stage_r[STAGES-1].valid & ~res_ready);
    assign accept_s  = ap_rst_n & found_s & advance_s;

    // Round-robin scan: first valid requester at or after rr_ptr, modulo N_REQ.
    always_comb begin
        int idx_v;
        idx_v   = 0;
        found_s = 1'b0;
        grant_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_v = (int'(rr_ptr_r) + k) % N_REQ;
            if (!found_s && req_valid[idx_v]) begin
                found_s = 1'b1;
                grant_s = IDW'(idx_v);
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot grant, withheld during stall and while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (accept_s) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Pointer moves to the requester after the winner.
    always_comb begin
        if (int'(grant_s) == N_REQ - 1) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_s + IDW'(1);
        end
    end

    assign a_sel_s = req_a[int'(grant_s)*DIN0_W +: DIN0_W];
    assign b_sel_s = req_b[int'(grant_s)*DIN1_W +: DIN1_W];

    threshold2_mul_core #(
        .DIN0_W (DIN0_W),
        .DIN1_W (DIN1_W),
        .DOUT_W (DOUT_W)
    ) u_core (
        .a (a_sel_s),
        .b (b_sel_s),
        .p (prod_s)
    );

    // Next pipeline contents: shift on advance (bubbles kept), freeze otherwise.
    always_comb begin
        if (advance_s) begin
            stage_next_s[0].valid = accept_s;
            stage_next_s[0].id    = ID_MAX_W'(grant_s);
            stage_next_s[0].data  = DATA_MAX_W'(prod_s);
            for (int s = 1; s < STAGES; s++) begin
                stage_next_s[s] = stage_r[s-1];
            end
        end else begin
            stage_next_s = stage_r;
        end
    end

    // busy is registered from the next-state valids so it tracks the stages exactly.
    always_comb begin
        busy_next_s = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            busy_next_s = busy_next_s | stage_next_s[s].valid;
        end
    end

    // Pipeline, arbitration pointer, busy flag and accept counter.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_r[s] <= '0;
            end
            rr_ptr_r   <= '0;
            busy_r     <= 1'b0;
            op_count_r <= 32'd0;
        end else begin
            stage_r <= stage_next_s;
            busy_r  <= busy_next_s;
            if (accept_s) begin
                rr_ptr_r   <= rr_next_s;
                op_count_r <= op_count_r + 32'd1;
            end else begin
                rr_ptr_r   <= rr_ptr_r;
                op_count_r <= op_count_r;
            end
        end
    end

    assign res_valid = stage_r[STAGES-1].valid;
    assign res_id    = IDW'(stage_r[STAGES-1].id);
    assign res_data  = DOUT_W'(stage_r[STAGES-1].data);
    assign busy      = busy_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_threshold2_mul_arb.sv
// Self-checking bench for threshold2_mul_arb: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model every cycle.
module tb_threshold2_mul_arb;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int BW = 14;
    localparam int DW = 21;
    localparam int ST = 2;
    localparam int IW = 2;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic            res_valid;
    logic            res_ready;
    logic [IW-1:0]   res_id;
    logic [DW-1:0]   res_data;
    logic            busy;
    logic [31:0]     op_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit      v;
        int      id;
        longint  d;
    } ent_t;

    ent_t       pipe[$];
    int         m_rr;
    bit [31:0]  m_cnt;
    logic [N-1:0] smp_ready;

    threshold2_mul_arb #(
        .N_REQ (N), .DIN0_W (AW), .DIN1_W (BW), .DOUT_W (DW), .STAGES (ST)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ent_t e;
        e.v = 1'b0; e.id = 0; e.d = 0;
        pipe.delete();
        for (int i = 0; i < ST; i++) pipe.push_back(e);
        m_rr  = 0;
        m_cnt = 32'd0;
    endtask

    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic longint prod(input int g);
        longint pa, pb;
        pa = longint'(req_a[g*AW +: AW]);
        pb = longint'(req_b[g*BW +: BW]);
        return (pa * pb) % (longint'(1) << DW);
    endfunction

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*AW +: AW] = AW'(a);
        req_b[i*BW +: BW] = BW'(b);
    endtask

    // Called just after a falling edge with inputs applied: compare, then clock the model.
    task automatic step();
        int           g;
        bit           stall, bz;
        logic [N-1:0] er;
        ent_t         last, ne;
        #1;
        last  = pipe[ST-1];
        stall = last.v && !res_ready;
        g     = m_winner();
        er    = '0;
        if (g >= 0 && !stall) er[g] = 1'b1;
        smp_ready = req_ready;
        chk("req_ready", req_ready, er);
        chk("res_valid", res_valid, last.v);
        if (last.v) begin
            chk("res_id", res_id, last.id);
            chk("res_data", res_data, last.d);
        end
        bz = 1'b0;
        foreach (pipe[i]) bz |= pipe[i].v;
        chk("busy", busy, bz);
        chk("op_count", op_count, m_cnt);
        @(posedge ap_clk);
        if (!stall) begin
            ne.v  = (g >= 0);
            ne.id = (g >= 0) ? g : 0;
            ne.d  = (g >= 0) ? prod(g) : 0;
            pipe.push_front(ne);
            void'(pipe.pop_back());
            if (g >= 0) begin
                m_rr  = (g + 1) % N;
                m_cnt = m_cnt + 32'd1;
            end
        end
        @(negedge ap_clk);
    endtask

    initial begin
        ap_rst_n  = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        model_reset();

        // Reset held with random inputs: everything reads zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            req_valid = N'($urandom);
            req_a     = $urandom;
            req_b     = {$urandom, $urandom};
            res_ready = 1'($urandom);
            #1;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_id", res_id, 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_op_count", op_count, 0);
        end
        @(negedge ap_clk);
        ap_rst_n  = 1'b1;
        res_ready = 1'b1;

        // Fairness: everyone valid, grants rotate 0,1,2,3,...
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            req_a = $urandom;
            req_b = {$urandom, $urandom};
            step();
            chk("fair_grant", smp_ready, 4'b0001 << (k % 4));
            if (k >= 1) chk("fair_res_id", res_id, (k - 1) % 4);
        end
        req_valid = '0;
        step();
        step();

        // Single request from requester 2: 3*5 arrives two cycles after the request cycle.
        req_valid = 4'b0100;
        set_req(2, 3, 5);
        step();
        chk("single_grant", smp_ready, 4'b0100);
        chk("single_lat1_valid", res_valid, 0);
        req_valid = '0;
        step();
        chk("single_grant_off", smp_ready, 0);
        chk("single_valid", res_valid, 1);
        chk("single_id", res_id, 2);
        chk("single_data", res_data, 15);
        chk("single_count", op_count, 9);
        step();
        chk("single_done", res_valid, 0);

        // Truncation: 255*16383 mod 2^21, then a zero operand.
        req_valid = 4'b0010;
        set_req(1, 255, 16383);
        step();
        req_valid = 4'b0001;
        set_req(0, 0, 16383);
        step();
        chk("trunc_id", res_id, 1);
        chk("trunc_data", res_data, 2080513);
        req_valid = '0;
        step();
        chk("zero_valid", res_valid, 1);
        chk("zero_id", res_id, 0);
        chk("zero_data", res_data, 0);
        step();

        // Back-pressure: stall three cycles with result 0 at the head.
        req_valid = 4'b0001;
        set_req(0, 17, 1000);
        step();
        req_valid = 4'b0010;
        set_req(1, 200, 9999);
        step();
        req_valid = 4'b0100;
        set_req(2, 99, 12345);
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_no_grant", smp_ready, 0);
            chk("bp_hold_id", res_id, 0);
            chk("bp_hold_data", res_data, 17000);
        end
        res_ready = 1'b1;
        step();
        chk("bp_release_grant", smp_ready, 4'b0100);
        chk("bp_order1", res_id, 1);
        req_valid = '0;
        step();
        chk("bp_order2", res_id, 2);
        step();
        chk("bp_drained", res_valid, 0);

        // Sparse: move pointer to 1, then only requester 3 is valid.
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1000;
        step();
        chk("sparse_grant", smp_ready, 4'b1000);
        req_valid = 4'b1111;
        step();
        chk("sparse_wrap_ptr", smp_ready, 4'b0001);
        req_valid = '0;
        step();
        step();

        // Random traffic with random back-pressure and extreme operands now and then.
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom);
            req_a     = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
            req_b     = {$urandom, $urandom};
            res_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        req_valid = '0;
        res_ready = 1'b1;
        step();
        step();

        // Counter wrap at 2^32.
        force dut.op_count_r = 32'hFFFF_FFFE;
        #1;
        release dut.op_count_r;
        m_cnt = 32'hFFFF_FFFE;
        req_valid = 4'b0001;
        step();
        chk("wrap_max", op_count, 32'hFFFF_FFFF);
        step();
        chk("wrap_zero", op_count, 0);

        // Asynchronous reset with entries in flight clears outputs before any edge.
        req_valid = '1;
        step();
        step();
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_res_valid", res_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_op_count", op_count, 0);
        chk("arst_req_ready", req_ready, 0);
        model_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();
        chk("arst_first_grant", smp_ready, 4'b0001);
        req_valid = '0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
